// File: rtl/accel_pad_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : accel_pad_loader_if
// Brief    : Message-stream and accelerator memory/control bundle for the
//            pad loader.
// Revision : 1.0
// ============================================================================
interface accel_pad_loader_if #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_data;
    logic                      in_last;
    logic [2:0]                in_bytes;
    logic                      mem_en;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic                      mem_we;
    logic [3:0]                mem_be;
    logic [MEM_DATA_WIDTH-1:0] mem_wdata;
    logic                      start;
    logic                      done;
    logic                      busy;
    logic                      error;

    // The loader side drives the memory port and control pulses.
    modport master (
        input  in_valid, in_data, in_last, in_bytes, done,
        output in_ready, mem_en, mem_addr, mem_we, mem_be, mem_wdata,
               start, busy, error
    );

    modport slave (
        output in_valid, in_data, in_last, in_bytes, done,
        input  in_ready, mem_en, mem_addr, mem_we, mem_be, mem_wdata,
               start, busy, error
    );
endinterface
`default_nettype wire

// File: rtl/accel_pad_loader.sv
`default_nettype none
// ============================================================================
// Module   : accel_pad_loader
// Brief    : Streams one message into a Keccak rate block with pad10*1 and a
//            domain byte, then starts the accelerator and waits for done.
// Revision : 1.0
// ============================================================================
module accel_pad_loader #(
    parameter int         MEM_ADDR_WIDTH = 32,
    parameter int         MEM_DATA_WIDTH = 32,
    parameter int         RATE_BYTES     = 168,
    parameter logic [7:0] DOMAIN_BYTE    = 8'h06
) (
    input wire logic           clk,
    input wire logic           rst,
    accel_pad_loader_if.master bus
);
    localparam int c_RATE_WORDS = RATE_BYTES / 4;
    localparam int c_IDX_W      = (c_RATE_WORDS > 1) ? $clog2(c_RATE_WORDS) : 1;
    localparam int c_LEN_W      = c_IDX_W + 3;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_RATE_WORDS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_LEN_W-1:0] c_RATE_LEN = c_LEN_W'(RATE_BYTES);

    localparam logic [2:0] c_ST_LOAD  = 3'd0;
    localparam logic [2:0] c_ST_PAD   = 3'd1;
    localparam logic [2:0] c_ST_START = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;

    logic [2:0]                r_state;
    logic [c_IDX_W-1:0]        r_word_idx;
    logic                      r_dom_pending;
    logic                      r_mem_en;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]               r_mem_wdata;
    logic                      r_start;
    logic                      r_busy;
    logic                      r_error;

    logic                      w_accept;
    logic [2:0]                w_nb;
    logic [c_LEN_W-1:0]        w_len;
    logic                      w_at_end;
    logic [31:0]               w_last_word;
    logic [31:0]               w_pad_word;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_nb     = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
    assign w_len    = c_LEN_W'({r_word_idx, 2'b00}) + c_LEN_W'(w_nb);
    assign w_at_end = (r_word_idx == c_LAST_IDX);

    // Final message word: keep the valid bytes, then the domain byte, then zeros.
    always_comb begin
        w_last_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_nb) begin
                w_last_word[8*k +: 8] = bus.in_data[8*k +: 8];
            end else if (3'(k) == w_nb) begin
                w_last_word[8*k +: 8] = DOMAIN_BYTE;
            end
        end
        if (w_at_end) begin
            w_last_word[31:24] = w_last_word[31:24] | 8'h80;
        end
    end

    assign w_pad_word = {(w_at_end ? 8'h80 : 8'h00), 16'h0000,
                         (r_dom_pending ? DOMAIN_BYTE : 8'h00)};

    // Held low during reset even though the state register already reads LOAD.
    assign bus.in_ready  = !rst && ((r_state == c_ST_LOAD) || (r_state == c_ST_DRAIN));
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_en;
    assign bus.mem_be    = {4{r_mem_en}};
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = MEM_DATA_WIDTH'(r_mem_wdata);
    assign bus.start     = r_start;
    assign bus.busy      = r_busy;
    assign bus.error     = r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_LOAD;
            r_word_idx    <= '0;
            r_dom_pending <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            r_start  <= 1'b0;
            r_error  <= 1'b0;
            case (r_state)
                c_ST_LOAD: begin
                    if (w_accept) begin
                        if (bus.in_last) begin
                            if (w_len >= c_RATE_LEN) begin
                                // The offending word closes the message, so nothing is left to drain.
                                r_error    <= 1'b1;
                                r_word_idx <= '0;
                            end else begin
                                r_mem_en      <= 1'b1;
                                r_mem_addr    <= MEM_ADDR_WIDTH'(r_word_idx);
                                r_mem_wdata   <= w_last_word;
                                r_busy        <= 1'b1;
                                r_dom_pending <= (w_nb == 3'd4);
                                if (w_at_end) begin
                                    r_state <= c_ST_START;
                                end else begin
                                    r_state    <= c_ST_PAD;
                                    r_word_idx <= r_word_idx + c_IDX_ONE;
                                end
                            end
                        end else if (w_at_end) begin
                            r_error <= 1'b1;
                            r_state <= c_ST_DRAIN;
                        end else begin
                            r_mem_en    <= 1'b1;
                            r_mem_addr  <= MEM_ADDR_WIDTH'(r_word_idx);
                            r_mem_wdata <= bus.in_data;
                            r_word_idx  <= r_word_idx + c_IDX_ONE;
                        end
                    end
                end
                c_ST_PAD: begin
                    r_mem_en      <= 1'b1;
                    r_mem_addr    <= MEM_ADDR_WIDTH'(r_word_idx);
                    r_mem_wdata   <= w_pad_word;
                    r_dom_pending <= 1'b0;
                    if (w_at_end) begin
                        r_state <= c_ST_START;
                    end else begin
                        r_word_idx <= r_word_idx + c_IDX_ONE;
                    end
                end
                c_ST_START: begin
                    r_start <= 1'b1;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (bus.done) begin
                        r_state    <= c_ST_LOAD;
                        r_word_idx <= '0;
                        r_busy     <= 1'b0;
                    end
                end
                c_ST_DRAIN: begin
                    if (w_accept && bus.in_last) begin
                        r_state    <= c_ST_LOAD;
                        r_word_idx <= '0;
                    end
                end
                default: begin
                    r_state    <= c_ST_LOAD;
                    r_word_idx <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_accel_pad_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_accel_pad_loader
// Brief    : Directed and randomized messages checked against a byte-level
//            pad10*1 model of the rate block.
// Revision : 1.0
// ============================================================================
module tb_accel_pad_loader;
    localparam int         c_RATE_BYTES = 168;
    localparam int         c_RATE_WORDS = c_RATE_BYTES / 4;
    localparam logic [7:0] c_DOMAIN     = 8'h06;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    int          wr_addr_q [$];
    int          wr_cyc_q  [$];
    logic [31:0] wr_data_q [$];
    int          start_q   [$];
    int          err_q     [$];
    bit          bus_bad;
    logic [31:0] dut_w [c_RATE_WORDS];

    accel_pad_loader_if #(.MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32)) bus ();

    accel_pad_loader #(
        .MEM_ADDR_WIDTH (32),
        .MEM_DATA_WIDTH (32),
        .RATE_BYTES     (c_RATE_BYTES),
        .DOMAIN_BYTE    (c_DOMAIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: logs every write, start and error with its cycle number.
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            wr_addr_q.push_back(int'(bus.mem_addr));
            wr_cyc_q.push_back(cyc);
            wr_data_q.push_back(bus.mem_wdata);
            if (!(bus.mem_we === 1'b1 && bus.mem_be === 4'hF)) bus_bad = 1'b1;
        end else if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin
            bus_bad = 1'b1;
        end
        if (bus.start === 1'b1) start_q.push_back(cyc);
        if (bus.error === 1'b1) err_q.push_back(cyc);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_cyc_q.delete();
        wr_data_q.delete();
        start_q.delete();
        err_q.delete();
        bus_bad = 1'b0;
    endtask

    // Expected rate block word i for a message, straight from the padding rule.
    function automatic logic [31:0] model_word(input byte_q_t msg, input int i);
        logic [7:0] blk [c_RATE_BYTES];
        for (int b = 0; b < c_RATE_BYTES; b++) blk[b] = (b < msg.size()) ? msg[b] : 8'h00;
        blk[msg.size()] = c_DOMAIN;
        blk[c_RATE_BYTES-1] = blk[c_RATE_BYTES-1] | 8'h80;
        return {blk[4*i+3], blk[4*i+2], blk[4*i+1], blk[4*i]};
    endfunction

    // Called at a negedge; returns the cycle in which the handshake was high.
    task automatic send_word(input logic [31:0] data, input logic last,
                             input logic [2:0] nb, output int acc_cyc);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        bus.in_bytes = nb;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            vectors++;
            miscompares++;
            $error("FAIL accept timeout: observed in_ready low for %0d cycles required accept", guard);
        end
        acc_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_msg(input byte_q_t msg, input bit junk, output int first, output int last_acc);
        int L  = msg.size();
        int nw = (L == 0) ? 1 : (L + 3) / 4;
        int acc;
        first = 0;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int nb;
            nb = (w == nw - 1) ? L - 4*w : 4;
            for (int k = 0; k < 4; k++)
                d[8*k +: 8] = (k < nb) ? msg[4*w+k] : (junk ? 8'($urandom) : 8'h00);
            send_word(d, (w == nw - 1), 3'(nb), acc);
            if (w == 0) first = acc;
        end
        last_acc = acc;
    endtask

    task automatic run_block(input string name, input byte_q_t msg, input bit junk, input bit noise);
        int  first, last_acc, guard;
        bit  order_ok;
        clear_log();
        bus.done = noise;
        send_msg(msg, junk, first, last_acc);
        guard = 0;
        while (bus.start !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        bus.done = 1'b0;
        if (guard >= 300) begin
            vectors++;
            miscompares++;
            $error("FAIL %s start timeout: observed no start required one", name);
        end
        repeat (2) @(negedge clk);

        for (int i = 0; i < c_RATE_WORDS; i++) dut_w[i] = 'x;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] >= 0 && wr_addr_q[i] < c_RATE_WORDS) dut_w[wr_addr_q[i]] = wr_data_q[i];
        for (int i = 0; i < c_RATE_WORDS; i++)
            check($sformatf("%s L=%0d word %0d", name, msg.size(), i), dut_w[i], model_word(msg, i));

        order_ok = (wr_addr_q.size() == c_RATE_WORDS);
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != i || wr_cyc_q[i] != first + 1 + i) order_ok = 1'b0;
        check({name, " write count"}, wr_addr_q.size(), c_RATE_WORDS);
        check({name, " write order/timing"}, order_ok, 1'b1);
        check({name, " start count"}, start_q.size(), 1);
        check({name, " start timing"}, (start_q.size() > 0) ? start_q[0] : -1, first + 1 + c_RATE_WORDS);
        check({name, " no error"}, err_q.size(), 0);
        check({name, " we/be"}, bus_bad, 1'b0);

        // WAIT: offered words are refused and the memory stays quiet.
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_bytes = 3'd0;
        bus.in_data  = $urandom;
        repeat (3) @(negedge clk);
        check({name, " wait in_ready"}, bus.in_ready, 1'b0);
        check({name, " wait busy"}, bus.busy, 1'b1);
        check({name, " wait no writes"}, wr_addr_q.size(), c_RATE_WORDS);
        bus.in_valid = 1'b0;
        bus.done     = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        check({name, " done->in_ready"}, bus.in_ready, 1'b1);
        check({name, " done->busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        byte_q_t msg;
        int      acc, acc2, a42;
        bit      w41;
        int      lens [5] = '{164, 163, 160, 1, 4};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.in_bytes = '0;
        bus.done     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", bus.in_ready, 1'b0);
        check("reset ctrl", {bus.mem_en, bus.mem_we, bus.mem_be, bus.start, bus.busy, bus.error}, 0);
        check("reset addr/data", {bus.mem_addr, bus.mem_wdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", bus.in_ready, 1'b1);

        msg = {};
        run_block("empty", msg, 1'b0, 1'b0);
        check("empty addr0", dut_w[0], 32'h0000_0006);
        check("empty addr41", dut_w[41], 32'h8000_0000);

        msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_block("five", msg, 1'b0, 1'b0);
        check("five addr0", dut_w[0], 32'h4433_2211);
        check("five addr1", dut_w[1], 32'h0000_0655);

        msg = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_block("exact", msg, 1'b0, 1'b0);
        check("exact addr0", dut_w[0], 32'hDDCC_BBAA);
        check("exact addr1", dut_w[1], 32'h0000_0006);

        msg = {};
        for (int i = 0; i < 164; i++) msg.push_back(8'($urandom));
        msg.push_back(8'hAA);
        msg.push_back(8'hBB);
        msg.push_back(8'hCC);
        run_block("max", msg, 1'b1, 1'b0);
        check("max addr41", dut_w[41], 32'h86CC_BBAA);

        foreach (lens[j]) begin
            msg = {};
            for (int i = 0; i < lens[j]; i++) msg.push_back(8'($urandom));
            run_block("edge", msg, 1'b1, 1'b1);
        end

        repeat (8) begin
            msg = {};
            repeat ($urandom_range(0, c_RATE_BYTES - 1)) msg.push_back(8'($urandom));
            run_block("rand", msg, 1'b1, 1'($urandom_range(0, 1)));
        end

        // Overflow: 42 full non-last words, then a drained tail.
        clear_log();
        a42 = 0;
        for (int w = 0; w < c_RATE_WORDS; w++) begin
            send_word($urandom, 1'b0, 3'd4, acc);
            a42 = acc;
        end
        for (int w = 0; w < 3; w++) send_word($urandom, 1'b0, 3'd4, acc);
        send_word($urandom, 1'b1, 3'd2, acc);
        repeat (4) @(negedge clk);
        w41 = 1'b0;
        foreach (wr_addr_q[i]) if (wr_addr_q[i] == c_RATE_WORDS - 1) w41 = 1'b1;
        check("overflow error count", err_q.size(), 1);
        check("overflow error timing", (err_q.size() > 0) ? err_q[0] : -1, a42 + 1);
        check("overflow writes", wr_addr_q.size(), c_RATE_WORDS - 1);
        check("overflow addr41 untouched", w41, 1'b0);
        check("overflow no start", start_q.size(), 0);
        check("overflow in_ready", bus.in_ready, 1'b1);
        msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_block("after overflow", msg, 1'b1, 1'b0);

        // Reset in the middle of PAD.
        clear_log();
        msg = {};
        send_msg(msg, 1'b0, acc, acc2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset mid-PAD outputs", {bus.in_ready, bus.mem_en, bus.mem_we, bus.mem_be, bus.start,
                                        bus.busy, bus.error, bus.mem_addr, bus.mem_wdata}, 0);
        clear_log();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("no writes after reset", wr_addr_q.size(), 0);
        check("no start after reset", start_q.size(), 0);
        msg = {};
        repeat ($urandom_range(1, 20)) msg.push_back(8'($urandom));
        run_block("after reset", msg, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
